// File: rtl/sync_gray_ptr.sv
// rtl/sync_gray_ptr.sv - N-stage Gray pointer synchroniser with binary output, advance count and multi-bit error flag
// Optional error counter output err_cnt is built when SYNC_ERRCNT_EN is defined.
module sync_gray_ptr #(
  parameter int ADDR_WIDTH = 4,
  parameter int STAGES     = 2
) (
  input  logic                  rclk,
  input  logic                  rrst,
  input  logic [ADDR_WIDTH:0]   wptr_gray,
  input  logic                  err_clr,
  output logic [ADDR_WIDTH:0]   sync_gray,
  output logic [ADDR_WIDTH:0]   sync_bin,
  output logic [ADDR_WIDTH:0]   advance,
  output logic                  ptr_valid,
  output logic                  err_multibit
`ifdef SYNC_ERRCNT_EN
  , output logic [7:0]          err_cnt
`endif
);

  localparam int PW = ADDR_WIDTH + 1;
  localparam int CW = $clog2(STAGES + 2);
  localparam logic [CW-1:0] WARM_MAX = CW'(STAGES + 1);

  generate
    if (STAGES < 2 || STAGES > 4) begin : g_bad_stages
      $error("sync_gray_ptr: STAGES must be in 2..4");
    end
  endgenerate

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] res;
    for (int i = 0; i < PW; i++) begin
      res[i] = ^(g >> i);
    end
    return res;
  endfunction

  logic [STAGES-1:0][PW-1:0] sync_q, sync_d;
  logic [PW-1:0]             gray_q, gray_d;
  logic [PW-1:0]             bin_q, bin_d;
  logic [PW-1:0]             prev_bin_q, prev_bin_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic                      err_q, err_d;
  logic [PW-1:0]             diff;
  logic                      err_det;

  // Flop 0 is the metastability-catching stage; nothing but wires between stages.
  assign sync_gray = sync_q[STAGES-1];
  assign ptr_valid = (cnt_q == WARM_MAX);
  assign diff      = sync_gray ^ gray_q;
  assign err_det   = ptr_valid && ((diff & (diff - 1'b1)) != '0);

  always_comb begin
    sync_d     = {sync_q[STAGES-2:0], wptr_gray};
    gray_d     = sync_gray;
    bin_d      = gray2bin(sync_gray);
    prev_bin_d = bin_q;
    cnt_d      = ptr_valid ? cnt_q : cnt_q + 1'b1;
    err_d      = err_det | (err_q & ~err_clr);
  end

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      sync_q     <= '0;
      gray_q     <= '0;
      bin_q      <= '0;
      prev_bin_q <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      gray_q     <= gray_d;
      bin_q      <= bin_d;
      prev_bin_q <= prev_bin_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
    end
  end

  assign sync_bin     = bin_q;
  assign advance      = bin_q - prev_bin_q;
  assign err_multibit = err_q;

`ifdef SYNC_ERRCNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  // A detection in the clear cycle leaves the count at exactly one.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_det) begin
      if (err_clr)                err_cnt_d = 8'd1;
      else if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
    end else if (err_clr) begin
      err_cnt_d = 8'd0;
    end
  end

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) err_cnt_q <= 8'd0;
    else      err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_sync_gray_ptr.sv
// tb/tb_sync_gray_ptr.sv - directed checks of sync_gray_ptr at STAGES=2 and STAGES=4
module tb_sync_gray_ptr;

  logic       rclk = 1'b0;
  logic       rrst, err_clr;
  logic [4:0] wptr_gray;
  logic [4:0] sync_gray, sync_bin, advance;
  logic       ptr_valid, err_multibit;

  logic       rst_b, clr_b;
  logic [4:0] wptr_b;
  logic [4:0] sg_b, sb_b, adv_b;
  logic       pv_b, err_b;

`ifdef SYNC_ERRCNT_EN
  logic [7:0] err_cnt, cnt_b;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 rclk = ~rclk;

  sync_gray_ptr #(.ADDR_WIDTH(4), .STAGES(2)) dut (
    .rclk(rclk), .rrst(rrst), .wptr_gray(wptr_gray), .err_clr(err_clr),
    .sync_gray(sync_gray), .sync_bin(sync_bin), .advance(advance),
    .ptr_valid(ptr_valid), .err_multibit(err_multibit)
`ifdef SYNC_ERRCNT_EN
    , .err_cnt(err_cnt)
`endif
  );

  sync_gray_ptr #(.ADDR_WIDTH(4), .STAGES(4)) dut4 (
    .rclk(rclk), .rrst(rst_b), .wptr_gray(wptr_b), .err_clr(clr_b),
    .sync_gray(sg_b), .sync_bin(sb_b), .advance(adv_b),
    .ptr_valid(pv_b), .err_multibit(err_b)
`ifdef SYNC_ERRCNT_EN
    , .err_cnt(cnt_b)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  task automatic check_cnt(input string tag, input logic [7:0] exp);
`ifdef SYNC_ERRCNT_EN
    check(tag, err_cnt, exp);
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rrst = 1'b1; err_clr = 1'b0; wptr_gray = 5'h00;
    rst_b = 1'b1; clr_b = 1'b0; wptr_b = 5'h00;
    #2;
    check("rst_sync_gray", sync_gray, 0);
    check("rst_sync_bin", sync_bin, 0);
    check("rst_advance", advance, 0);
    check("rst_ptr_valid", ptr_valid, 0);
    check("rst_err", err_multibit, 0);
    check_cnt("rst_err_cnt", 8'd0);

    // warm-up: valid rises after the third edge
    @(negedge rclk); rrst = 1'b0;
    tick(); check("warm_e1_valid", ptr_valid, 0); check("warm_e1_bin", sync_bin, 0);
    tick(); check("warm_e2_valid", ptr_valid, 0); check("warm_e2_adv", advance, 0);
    tick(); check("warm_e3_valid", ptr_valid, 1); check("warm_e3_err", err_multibit, 0);
    tick(); check("warm_e4_valid", ptr_valid, 1);

    // single increment 0 -> 1
    wptr_gray = 5'h01;
    tick(); check("inc_n_gray", sync_gray, 0);
    tick(); check("inc_n1_gray", sync_gray, 1); check("inc_n1_bin", sync_bin, 0);
    tick(); check("inc_n2_bin", sync_bin, 1); check("inc_n2_adv", advance, 1);
    tick(); check("inc_n3_adv", advance, 0);

    // settle at binary 30, then walk 31, 0, 1 across the wrap
    wptr_gray = 5'h11;
    repeat (4) tick();
    check("walk_bin30", sync_bin, 30); check("walk_adv30", advance, 0);
    wptr_gray = 5'h10; tick();
    wptr_gray = 5'h00; tick(); check("walk_gray_10", sync_gray, 5'h10);
    wptr_gray = 5'h01; tick(); check("walk_bin31", sync_bin, 31); check("walk_adv31", advance, 1);
    tick(); check("walk_bin0", sync_bin, 0); check("walk_adv0", advance, 1);
    tick(); check("walk_bin1", sync_bin, 1); check("walk_adv1", advance, 1);
    check("walk_err", err_multibit, 0);
    tick(); check("walk_adv_idle", advance, 0);

    // two-bit jump 0x00 -> 0x03
    wptr_gray = 5'h00;
    repeat (4) tick();
    check("pre_err", err_multibit, 0);
    wptr_gray = 5'h03;
    tick();
    tick(); check("err_n1", err_multibit, 0);
    tick(); check("err_n2", err_multibit, 1); check_cnt("err_cnt_set", 8'd1);
    tick(); check("err_sticky", err_multibit, 1); check_cnt("err_cnt_hold", 8'd1);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    check("err_cleared", err_multibit, 0); check_cnt("err_cnt_clr", 8'd0);

    // detection and clear on the same edge: set wins
    wptr_gray = 5'h00;
    tick(); tick();
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    check("setclr_err", err_multibit, 1); check_cnt("setclr_cnt", 8'd1);
    tick(); check("setclr_hold", err_multibit, 1);
    wptr_gray = 5'h03;
    repeat (3) tick();
    check_cnt("err_cnt_incr", 8'd2);

    // reach binary 17 (gray 0x19), clear the error, then reset mid-stream
    wptr_gray = 5'h19;
    repeat (5) tick();
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    check("mid_bin17", sync_bin, 17); check("mid_err_clr", err_multibit, 0);
    rrst = 1'b1; #1;
    check("mid_rst_gray", sync_gray, 0);
    check("mid_rst_bin", sync_bin, 0);
    check("mid_rst_adv", advance, 0);
    check("mid_rst_valid", ptr_valid, 0);
    @(negedge rclk); rrst = 1'b0;
    tick(); check("rewarm_e1", ptr_valid, 0);
    tick(); check("rewarm_e2", ptr_valid, 0);
    tick(); check("rewarm_e3", ptr_valid, 1); check("rewarm_bin", sync_bin, 17);
    check("rewarm_err_suppressed", err_multibit, 0);
    tick(); tick(); check("rewarm_err_later", err_multibit, 0);

    // STAGES=4 instance
    @(negedge rclk); rst_b = 1'b0;
    for (int e = 1; e <= 5; e++) begin
      tick();
      check($sformatf("s4_valid_e%0d", e), pv_b, (e == 5) ? 1 : 0);
    end
    wptr_b = 5'h01;
    tick(); tick(); tick(); check("s4_n2_gray", sg_b, 0);
    tick(); check("s4_n3_gray", sg_b, 1); check("s4_n3_bin", sb_b, 0);
    tick(); check("s4_n4_bin", sb_b, 1); check("s4_n4_adv", adv_b, 1);
    check("s4_err", err_b, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
